store_unit: RTL and testbench

//  Write-side counterpart of the stage_W load path: formats SB/SH/SW stores into word-aligned

---
 rtl/store_unit_pkg.sv | 49 ++++
 rtl/store_unit_if.sv | 34 +++
 rtl/store_fifo.sv | 74 +++++++
 rtl/store_unit.sv | 104 ++++++++++
 tb/tb_store_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_unit_pkg.sv
// Shared alucodes, hardware-counter address and store formatting helpers.
package store_unit_pkg;

    // Load and store alucodes as decoded in stage D
    localparam logic [5:0] ALU_LB  = 6'd16;
    localparam logic [5:0] ALU_LH  = 6'd17;
    localparam logic [5:0] ALU_LW  = 6'd18;
    localparam logic [5:0] ALU_LBU = 6'd19;
    localparam logic [5:0] ALU_LHU = 6'd20;
    localparam logic [5:0] ALU_SB  = 6'd21;
    localparam logic [5:0] ALU_SH  = 6'd22;
    localparam logic [5:0] ALU_SW  = 6'd23;

    localparam logic [31:0] HW_ADDR_DEFAULT = 32'h0000_FF00;

    // Store-buffer entry: {word_addr[29:0], wdata[31:0], wstrb[3:0], is_hw}
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned ENTRY_W = WADDR_W + 32 + 4 + 1;

    function automatic logic is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] off);
        return ((code == ALU_SH) && off[0]) || ((code == ALU_SW) && (off != 2'b00));
    endfunction

    // Replicate the stored lanes so the strobe alone selects the target bytes
    function automatic logic [31:0] fmt_data(input logic [5:0] code, input logic [31:0] d);
        logic [31:0] r;
        case (code)
            ALU_SB:  r = {4{d[7:0]}};
            ALU_SH:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] fmt_strb(input logic [5:0] code, input logic [1:0] off);
        logic [3:0] r;
        case (code)
            ALU_SB:  r = 4'b0001 << off;
            ALU_SH:  r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store-side bus of stage M: store request, load hazard probe, memory write and counter write.
interface store_unit_if;
    logic        st_valid;
    logic [5:0]  st_alucode;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        misalign_err;
    logic        ld_check_valid;
    logic [31:0] ld_check_addr;
    logic        ld_hazard;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wready;
    logic        hc_IN_valid;
    logic [31:0] hc_IN_data;
    logic        buf_empty;

    // Pipeline / memory side
    modport master (
        output st_valid, st_alucode, st_addr, st_data, ld_check_valid, ld_check_addr, mem_wready,
        input  st_ready, misalign_err, ld_hazard, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
               hc_IN_valid, hc_IN_data, buf_empty
    );

    // Store unit side
    modport slave (
        input  st_valid, st_alucode, st_addr, st_data, ld_check_valid, ld_check_addr, mem_wready,
        output st_ready, misalign_err, ld_hazard, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
               hc_IN_valid, hc_IN_data, buf_empty
    );
endinterface

// File: rtl/store_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO exposing per-entry valids and a key field
// (the top KEY_W bits of each entry) for associative lookups.
module store_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KEY_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic                        empty,
    output logic                        full,
    output logic [DEPTH-1:0]            entry_valid,
    output logic [DEPTH-1:0][KEY_W-1:0] entry_key
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]               count_q, count_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
    logic                         do_push, do_pop;
    logic [PTR_W-1:0]             off;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_MAX);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count state; reset discards every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Entry storage; contents are meaningless unless flagged valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        off = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off            = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, off} < count_q);
            entry_key[i]   = mem_q[i][WIDTH-1 -: KEY_W];
        end
    end

endmodule

// File: rtl/store_unit.sv
// Stage-M store unit: formats SB/SH/SW, buffers them, drains in order to data memory or to
// the hardware counter, and flags loads that hit a word with a pending store.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] HW_ADDR = HW_ADDR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    store_unit_if.slave    bus
);
    logic                            accept, misaligned, push, pop;
    logic                            fifo_empty, fifo_full, misalign_q, st_is_hw;
    logic [ENTRY_W-1:0]              push_entry, head;
    logic [DEPTH-1:0]                entry_valid;
    logic [DEPTH-1:0][WADDR_W-1:0]   entry_waddr;
    logic [WADDR_W-1:0]              head_waddr;
    logic [31:0]                     head_wdata;
    logic [3:0]                      head_wstrb;
    logic                            head_is_hw;
    logic                            mem_wvalid, hc_valid, hazard;
    logic [31:0]                     mem_waddr, mem_wdata, hc_data;
    logic [3:0]                      mem_wstrb;

    assign accept     = bus.st_valid & ~fifo_full & is_store(bus.st_alucode);
    assign misaligned = is_misaligned(bus.st_alucode, bus.st_addr[1:0]);
    assign push       = accept & ~misaligned;
    // Only a full-word store claims the counter; narrower stores there go to memory
    assign st_is_hw   = (bus.st_alucode == ALU_SW) && ({bus.st_addr[31:2], 2'b00} == HW_ADDR);
    assign push_entry = {bus.st_addr[31:2],
                         fmt_data(bus.st_alucode, bus.st_data),
                         fmt_strb(bus.st_alucode, bus.st_addr[1:0]),
                         st_is_hw};
    assign {head_waddr, head_wdata, head_wstrb, head_is_hw} = head;

    store_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .KEY_W (WADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_data   (push_entry),
        .pop         (pop),
        .head_data   (head),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .entry_valid (entry_valid),
        .entry_key   (entry_waddr)
    );

    // Misalignment pulse for the cycle after a dropped store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= accept & misaligned;
    end

    // Drain the head: counter writes pop immediately, memory writes wait for wready
    always_comb begin
        mem_wvalid = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        hc_valid   = 1'b0;
        hc_data    = '0;
        if (!fifo_empty) begin
            if (head_is_hw) begin
                hc_valid = 1'b1;
                hc_data  = head_wdata;
            end else begin
                mem_wvalid = 1'b1;
                mem_waddr  = {head_waddr, 2'b00};
                mem_wdata  = head_wdata;
                mem_wstrb  = head_wstrb;
            end
        end
        pop = hc_valid | (mem_wvalid & bus.mem_wready);
    end

    // Word-granular load hazard against every live entry, ignoring strobes
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entry_valid[i] &&
                ((({entry_waddr[i], 2'b00} ^ bus.ld_check_addr) & 32'hFFFF_FFFC) == '0)) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.ld_hazard    = bus.ld_check_valid & hazard;
    assign bus.st_ready     = ~fifo_full;
    assign bus.buf_empty    = fifo_empty;
    assign bus.misalign_err = misalign_q;
    assign bus.mem_wvalid   = mem_wvalid;
    assign bus.mem_waddr    = mem_waddr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.mem_wstrb    = mem_wstrb;
    assign bus.hc_IN_valid  = hc_valid;
    assign bus.hc_IN_data   = hc_data;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HWA   = 32'h0000_FF00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_unit_if bus();

    store_unit #(
        .DEPTH   (DEPTH),
        .HW_ADDR (HWA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        hw;
    } ent_t;

    ent_t        q[$];
    logic        exp_mis = 1'b0;
    logic        cmp_en  = 1'b0;
    logic [31:0] drained[$];
    int          hc_pulses = 0;

    always @(posedge clk) begin
        logic        acc, mis, is_st;
        logic [1:0]  o;
        ent_t        e;
        if (!rst_n) begin
            q.delete();
            exp_mis = 1'b0;
        end else begin
            is_st = (bus.st_alucode == ALU_SB) || (bus.st_alucode == ALU_SH) ||
                    (bus.st_alucode == ALU_SW);
            acc   = bus.st_valid && (q.size() < DEPTH) && is_st;
            if (q.size() > 0 && (q[0].hw || bus.mem_wready)) void'(q.pop_front());
            mis = 1'b0;
            if (acc) begin
                o   = bus.st_addr[1:0];
                mis = (bus.st_alucode == ALU_SH && o[0]) || (bus.st_alucode == ALU_SW && o != 0);
                e.addr = bus.st_addr & 32'hFFFF_FFFC;
                if (bus.st_alucode == ALU_SB) begin
                    e.data = 32'h0101_0101 * {24'd0, bus.st_data[7:0]};
                    e.strb = 4'(1 << o);
                end else if (bus.st_alucode == ALU_SH) begin
                    e.data = 32'h0001_0001 * {16'd0, bus.st_data[15:0]};
                    e.strb = 4'(3 << o);
                end else begin
                    e.data = bus.st_data;
                    e.strb = 4'hF;
                end
                e.hw = (bus.st_alucode == ALU_SW) && (e.addr == HWA);
                if (!mis) q.push_back(e);
            end
            exp_mis = mis;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        ent_t h;
        logic ne, hz;
        if (rst_n && cmp_en) begin
            ne = (q.size() > 0);
            h  = ne ? q[0] : '0;
            hz = 1'b0;
            foreach (q[i]) if (q[i].addr[31:2] == bus.ld_check_addr[31:2]) hz = 1'b1;
            check("m_st_ready", 32'(bus.st_ready), 32'(q.size() < DEPTH));
            check("m_buf_empty", 32'(bus.buf_empty), 32'(!ne));
            check("m_misalign", 32'(bus.misalign_err), 32'(exp_mis));
            check("m_ld_hazard", 32'(bus.ld_hazard), 32'(bus.ld_check_valid && hz));
            check("m_mem_wvalid", 32'(bus.mem_wvalid), 32'(ne && !h.hw));
            check("m_hc_valid", 32'(bus.hc_IN_valid), 32'(ne && h.hw));
            if (ne && !h.hw) begin
                check("m_waddr", bus.mem_waddr, h.addr);
                check("m_wdata", bus.mem_wdata, h.data);
                check("m_wstrb", 32'(bus.mem_wstrb), 32'(h.strb));
            end
            if (ne && h.hw) check("m_hc_data", bus.hc_IN_data, h.data);
        end
    end

    // Log DUT handshakes; wready only changes just after a rising edge
    always @(negedge clk) begin
        if (rst_n && bus.mem_wvalid && bus.mem_wready) drained.push_back(bus.mem_waddr);
        if (rst_n && bus.hc_IN_valid) hc_pulses++;
    end

    // ---------------- stimulus ----------------
    task automatic store(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] d);
        bus.st_valid   = 1'b1;
        bus.st_alucode = code;
        bus.st_addr    = addr;
        bus.st_data    = d;
        @(posedge clk);
        #1;
        bus.st_valid   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.buf_empty) break;
        end
        check(name, 32'(bus.buf_empty), 32'd1);
        step();
    endtask

    logic [31:0] exp_drain[11] = '{32'h100, 32'h200, 32'h204, 32'h400, 32'h404, 32'h408,
                                   32'h40C, 32'h410, 32'hFF00, 32'h300, 32'h600};

    initial begin
        logic acc5;
        bus.st_valid       = 1'b0;
        bus.st_alucode     = '0;
        bus.st_addr        = '0;
        bus.st_data        = '0;
        bus.ld_check_valid = 1'b0;
        bus.ld_check_addr  = '0;
        bus.mem_wready     = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_st_ready", 32'(bus.st_ready), 32'd1);
        check("rst_buf_empty", 32'(bus.buf_empty), 32'd1);
        check("rst_mem_wvalid", 32'(bus.mem_wvalid), 32'd0);
        check("rst_hc_valid", 32'(bus.hc_IN_valid), 32'd0);
        check("rst_misalign", 32'(bus.misalign_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // 1: SB byte lane 3
        bus.mem_wready = 1'b1;
        store(ALU_SB, 32'h103, 32'hAB);
        @(negedge clk);
        check("t1_wvalid", 32'(bus.mem_wvalid), 32'd1);
        check("t1_waddr", bus.mem_waddr, 32'h100);
        check("t1_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        check("t1_wstrb", 32'(bus.mem_wstrb), 32'h8);
        step();

        // 2: SH upper half then SW, in order
        bus.mem_wready = 1'b0;
        store(ALU_SH, 32'h202, 32'h1234_BEEF);
        store(ALU_SW, 32'h204, 32'hCAFE_F00D);
        @(negedge clk);
        check("t2_strb0", 32'(bus.mem_wstrb), 32'hC);
        check("t2_data0", bus.mem_wdata, 32'hBEEF_BEEF);
        step();
        bus.mem_wready = 1'b1;
        step();
        @(negedge clk);
        check("t2_strb1", 32'(bus.mem_wstrb), 32'hF);
        check("t2_data1", bus.mem_wdata, 32'hCAFE_F00D);
        step();

        // 3: fill with wready low, fifth store held off until a slot frees
        bus.mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) store(ALU_SW, 32'h400 + 32'(4 * i), 32'h1000_0000 + i);
        bus.st_valid   = 1'b1;
        bus.st_alucode = ALU_SW;
        bus.st_addr    = 32'h410;
        bus.st_data    = 32'h1000_0004;
        @(negedge clk);
        check("t3_full", 32'(bus.st_ready), 32'd0);
        check("t3_head", bus.mem_wdata, 32'h1000_0000);
        step();
        @(negedge clk);
        check("t3_stable", bus.mem_wdata, 32'h1000_0000);
        check("t3_full2", 32'(bus.st_ready), 32'd0);
        step();
        bus.mem_wready = 1'b1;
        acc5 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.st_ready) begin
                @(posedge clk);
                #1;
                acc5 = 1'b1;
                break;
            end
        end
        bus.st_valid = 1'b0;
        check("t3_fifth_accepted", 32'(acc5), 32'd1);
        wait_empty("t3_drained");

        // 4: SW to the counter word, then SB there goes to memory
        store(ALU_SW, HWA, 32'h5);
        @(negedge clk);
        check("t4_hc_valid", 32'(bus.hc_IN_valid), 32'd1);
        check("t4_hc_data", bus.hc_IN_data, 32'h5);
        check("t4_no_mem", 32'(bus.mem_wvalid), 32'd0);
        step();
        @(negedge clk);
        check("t4_hc_pulse_end", 32'(bus.hc_IN_valid), 32'd0);
        step();
        store(ALU_SB, HWA, 32'h77);
        @(negedge clk);
        check("t4_sb_mem", 32'(bus.mem_wvalid), 32'd1);
        check("t4_sb_waddr", bus.mem_waddr, 32'hFF00);
        check("t4_sb_wdata", bus.mem_wdata, 32'h7777_7777);
        check("t4_sb_wstrb", 32'(bus.mem_wstrb), 32'h1);
        check("t4_sb_no_hc", 32'(bus.hc_IN_valid), 32'd0);
        step();

        // 5: load hazard against a pending word
        bus.mem_wready = 1'b0;
        store(ALU_SW, 32'h300, 32'hDEAD);
        bus.ld_check_valid = 1'b1;
        bus.ld_check_addr  = 32'h302;
        @(negedge clk);
        check("t5_hit", 32'(bus.ld_hazard), 32'd1);
        step();
        bus.ld_check_addr = 32'h304;
        @(negedge clk);
        check("t5_other_word", 32'(bus.ld_hazard), 32'd0);
        step();
        bus.ld_check_addr = 32'h302;
        bus.mem_wready    = 1'b1;
        @(negedge clk);
        check("t5_hit_while_popping", 32'(bus.ld_hazard), 32'd1);
        step();
        @(negedge clk);
        check("t5_after_pop", 32'(bus.ld_hazard), 32'd0);
        step();
        bus.ld_check_valid = 1'b0;

        // 6: misaligned SW dropped, non-store ignored, reset kills pending stores
        store(ALU_SW, 32'h101, 32'h1);
        @(negedge clk);
        check("t6_mis_pulse", 32'(bus.misalign_err), 32'd1);
        check("t6_mis_nothing", 32'(bus.buf_empty), 32'd1);
        step();
        @(negedge clk);
        check("t6_mis_end", 32'(bus.misalign_err), 32'd0);
        step();
        store(ALU_LW, 32'h500, 32'h1);
        @(negedge clk);
        check("t6_ignored", 32'(bus.buf_empty), 32'd1);
        step();
        bus.mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) store(ALU_SW, 32'h500 + 32'(4 * i), 32'h2000_0000 + i);
        @(negedge clk);
        check("t6_pending", 32'(bus.buf_empty), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
        check("t6_rst_empty", 32'(bus.buf_empty), 32'd1);
        check("t6_rst_ready", 32'(bus.st_ready), 32'd1);
        step();
        rst_n          = 1'b1;
        bus.mem_wready = 1'b1;
        @(negedge clk);
        check("t6_post_rst_empty", 32'(bus.buf_empty), 32'd1);
        check("t6_post_rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
        step();
        store(ALU_SW, 32'h600, 32'h600D);
        @(negedge clk);
        check("t6_post_rst_store", bus.mem_waddr, 32'h600);
        wait_empty("t6_drained");

        // Whole-run drain order and counter pulses
        check("drain_count", 32'(drained.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < drained.size()) check($sformatf("drain_%0d", i), drained[i], exp_drain[i]);
        end
        check("hc_pulses", 32'(hc_pulses), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
